// File: rtl/det_pkg.sv
// Shared encodings for the frame scheduler FSM and the 1011 sequence detector.
package det_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_GRANT  = 3'd1;
    localparam logic [2:0] ST_RUN    = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_REPORT = 3'd4;

    // Detector states name the longest matched prefix of 1011.
    localparam logic [1:0] DET_S0    = 2'd0;
    localparam logic [1:0] DET_S1    = 2'd1;
    localparam logic [1:0] DET_S10   = 2'd2;
    localparam logic [1:0] DET_S101  = 2'd3;

endpackage

// File: rtl/seq_det_1011.sv
// Overlapping 1011 detector (first bit first) with a registered match pulse.
module seq_det_1011 import det_pkg::*; (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic din,
    output logic match
);

    logic [1:0] st;
    logic [1:0] st_nxt;

    always_comb begin
        st_nxt = st;
        case (st)
            DET_S0:   st_nxt = din ? DET_S1   : DET_S0;
            DET_S1:   st_nxt = din ? DET_S1   : DET_S10;
            DET_S10:  st_nxt = din ? DET_S101 : DET_S0;
            // A completed match leaves its trailing 1 as the new prefix.
            DET_S101: st_nxt = din ? DET_S1   : DET_S10;
            default:  st_nxt = DET_S0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st    <= DET_S0;
            match <= 1'b0;
        end else if (clr) begin
            st    <= DET_S0;
            match <= 1'b0;
        end else begin
            match <= en && (st == DET_S101) && din;
            if (en) begin
                st <= st_nxt;
            end
        end
    end

endmodule

// File: rtl/det_sched.sv
// Round-robin scheduler that lends one 1011 detector to NREQ serial requesters,
// one FRAME_LEN-bit frame at a time, and reports the match count per frame.
module det_sched import det_pkg::*; #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned FRAME_LEN = 16,
    parameter int unsigned CNT_W     = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ-1:0]           din,
    output logic [NREQ-1:0]           gnt,
    output logic                      bit_rd,
    output logic                      done,
    output logic [$clog2(NREQ)-1:0]   done_id,
    output logic [CNT_W-1:0]          match_cnt
);

    localparam int unsigned IDW = $clog2(NREQ);

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [IDW-1:0]   winner;
    logic [IDW-1:0]   last_id;
    logic [IDW-1:0]   rr_pick;
    logic [CNT_W-1:0] bitcnt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             active;
    logic             win_req;
    logic             last_bit;
    logic             det_match;

    assign active   = (state == ST_GRANT) || (state == ST_RUN) || (state == ST_DRAIN);
    assign win_req  = req[winner];
    assign last_bit = (bitcnt == CNT_W'(FRAME_LEN - 1));
    assign bit_rd   = (state == ST_RUN);
    assign done     = (state == ST_REPORT);
    assign cnt_nxt  = (det_match && (cnt != '1)) ? cnt + 1'b1 : cnt;

    // Scanning from the far end lets the requester nearest last_id+1 win.
    always_comb begin
        rr_pick = last_id;
        for (int unsigned k = NREQ; k >= 1; k--) begin
            if (req[IDW'((32'(last_id) + k) % NREQ)]) begin
                rr_pick = IDW'((32'(last_id) + k) % NREQ);
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (active) begin
            gnt[winner] = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (|req) state_nxt = ST_GRANT;
            ST_GRANT:  state_nxt = win_req ? ST_RUN : ST_IDLE;
            ST_RUN: begin
                if (!win_req)      state_nxt = ST_IDLE;
                else if (last_bit) state_nxt = ST_DRAIN;
            end
            ST_DRAIN:  state_nxt = win_req ? ST_REPORT : ST_IDLE;
            ST_REPORT: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            winner    <= '0;
            last_id   <= IDW'(NREQ - 1);
            bitcnt    <= '0;
            cnt       <= '0;
            done_id   <= '0;
            match_cnt <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (state == ST_GRANT) ? '0 : cnt_nxt;
            case (state)
                ST_IDLE:  if (|req) winner <= rr_pick;
                ST_GRANT: bitcnt <= '0;
                ST_RUN:   bitcnt <= bitcnt + 1'b1;
                // The final bit's match pulse lands in DRAIN, so fold it in here.
                ST_DRAIN: begin
                    if (win_req) begin
                        done_id   <= winner;
                        match_cnt <= cnt_nxt;
                    end
                end
                default: ;
            endcase
            if ((state == ST_REPORT) || (active && !win_req)) begin
                last_id <= winner;
            end
        end
    end

    seq_det_1011 u_det (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state == ST_GRANT),
        .en    (bit_rd),
        .din   (din[winner]),
        .match (det_match)
    );

endmodule

// File: tb/tb_det_sched.sv
// Directed bench for det_sched: reset, single frames, patterns, abort, async reset, round-robin.
module tb_det_sched;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  din;
    logic [3:0]  gnt;
    logic        bit_rd;
    logic        done;
    logic [1:0]  done_id;
    logic [4:0]  match_cnt;

    logic [15:0] pat;
    logic [4:0]  bitpos;
    logic        cur_bit;

    int nvec;
    int nerr;

    det_sched #(
        .NREQ      (4),
        .FRAME_LEN (16),
        .CNT_W     (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .din       (din),
        .gnt       (gnt),
        .bit_rd    (bit_rd),
        .done      (done),
        .done_id   (done_id),
        .match_cnt (match_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requester model: serves pat MSB first, advancing on each bit_rd strobe.
    always @(posedge clk) begin
        if (bit_rd)      bitpos <= bitpos + 5'd1;
        else if (~|gnt)  bitpos <= 5'd0;
    end

    always_comb begin
        cur_bit = 1'b0;
        if (bitpos < 5'd16) cur_bit = pat[4'd15 - bitpos[3:0]];
    end

    // Non-granted lanes carry the inverted bit so a wrong lane select shows up.
    assign din = cur_bit ? gnt : ~gnt;

    task automatic run_frame(input logic [3:0] r, input logic [15:0] p,
                             output int cyc, output int strobes,
                             output logic seen, output logic [3:0] g1);
        @(posedge clk); #1;
        pat = p;
        req = r;
        cyc = 0;
        strobes = 0;
        @(posedge clk); #1;
        cyc = 1;
        g1 = gnt;
        while (!done && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (bit_rd) strobes++;
        end
        seen = done;
        req = 4'b0000;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req = 4'b0000;
        pat = 16'h0000;
        #2;
        nvec++; if (gnt !== 4'b0000) begin nerr++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
        nvec++; if (bit_rd !== 1'b0) begin nerr++; $display("FAIL reset_bit_rd: got %b want 0", bit_rd); end
        nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL reset_done: got %b want 0", done); end
        nvec++; if (done_id !== 2'd0) begin nerr++; $display("FAIL reset_done_id: got %0d want 0", done_id); end
        nvec++; if (match_cnt !== 5'd0) begin nerr++; $display("FAIL reset_match_cnt: got %0d want 0", match_cnt); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        int cyc;
        int strobes;
        logic seen;
        logic [3:0] g1;
        run_frame(4'b0001, 16'b1011011011000000, cyc, strobes, seen, g1);
        nvec++; if (g1 !== 4'b0001) begin nerr++; $display("FAIL single_gnt: got %b want 0001", g1); end
        nvec++; if (strobes != 16) begin nerr++; $display("FAIL single_strobes: got %0d want 16", strobes); end
        nvec++; if (seen !== 1'b1) begin nerr++; $display("FAIL single_done: got %b want 1", seen); end
        nvec++; if (cyc != 19) begin nerr++; $display("FAIL single_latency: got %0d want 19", cyc); end
        nvec++; if (done_id !== 2'd0) begin nerr++; $display("FAIL single_done_id: got %0d want 0", done_id); end
        nvec++; if (match_cnt !== 5'd3) begin nerr++; $display("FAIL single_match_cnt: got %0d want 3", match_cnt); end
        @(posedge clk); #1;
        nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL single_done_pulse: got %b want 0", done); end
        nvec++; if (gnt !== 4'b0000) begin nerr++; $display("FAIL single_gnt_idle: got %b want 0000", gnt); end
        nvec++; if (match_cnt !== 5'd3) begin nerr++; $display("FAIL single_cnt_hold: got %0d want 3", match_cnt); end
    endtask

    task automatic test_patterns;
        logic [15:0] pv [5];
        int          pc [5];
        int cyc;
        int strobes;
        logic seen;
        logic [3:0] g1;
        logic [1:0] eid;
        pv = '{16'h0000, 16'hFFFF, 16'h000B, 16'b1011011011011011, 16'b1010101010101011};
        pc = '{0, 0, 1, 5, 1};
        for (int i = 0; i < 5; i++) begin
            eid = 2'(i % 4);
            run_frame(4'b0001 << eid, pv[i], cyc, strobes, seen, g1);
            nvec++; if (seen !== 1'b1) begin nerr++; $display("FAIL pat%0d_done: got %b want 1", i, seen); end
            nvec++; if (done_id !== eid) begin nerr++; $display("FAIL pat%0d_done_id: got %0d want %0d", i, done_id, eid); end
            nvec++; if (match_cnt !== 5'(pc[i])) begin nerr++; $display("FAIL pat%0d_match_cnt: got %0d want %0d", i, match_cnt, pc[i]); end
        end
    endtask

    task automatic test_abort;
        logic seen;
        @(posedge clk); #1;
        pat = 16'hFFFF;
        req = 4'b0100;
        @(posedge clk); #1;
        nvec++; if (gnt !== 4'b0100) begin nerr++; $display("FAIL abort_gnt: got %b want 0100", gnt); end
        repeat (6) begin @(posedge clk); #1; end
        nvec++; if (bit_rd !== 1'b1) begin nerr++; $display("FAIL abort_in_run: got %b want 1", bit_rd); end
        req = 4'b0000;
        @(posedge clk); #1;
        nvec++; if (gnt !== 4'b0000) begin nerr++; $display("FAIL abort_gnt_drop: got %b want 0000", gnt); end
        nvec++; if (bit_rd !== 1'b0) begin nerr++; $display("FAIL abort_bit_rd: got %b want 0", bit_rd); end
        seen = done;
        repeat (10) begin @(posedge clk); #1; if (done) seen = 1'b1; end
        nvec++; if (seen !== 1'b0) begin nerr++; $display("FAIL abort_no_done: got %b want 0", seen); end
        nvec++; if (match_cnt !== 5'd1) begin nerr++; $display("FAIL abort_cnt_hold: got %0d want 1", match_cnt); end
        nvec++; if (done_id !== 2'd0) begin nerr++; $display("FAIL abort_id_hold: got %0d want 0", done_id); end
        req = 4'b1111;
        @(posedge clk); #1;
        nvec++; if (gnt !== 4'b1000) begin nerr++; $display("FAIL abort_next_rr: got %b want 1000", gnt); end
        req = 4'b0000;
        @(posedge clk); #1;
        nvec++; if (gnt !== 4'b0000) begin nerr++; $display("FAIL abort_in_grant: got %b want 0000", gnt); end
    endtask

    task automatic test_reset_mid;
        int w;
        @(posedge clk); #1;
        pat = 16'h000B;
        req = 4'b0010;
        @(posedge clk); #1;
        nvec++; if (gnt !== 4'b0010) begin nerr++; $display("FAIL rmid_gnt: got %b want 0010", gnt); end
        repeat (4) begin @(posedge clk); #1; end
        req = 4'b1111;
        @(posedge clk); #1;
        nvec++; if (gnt !== 4'b0010) begin nerr++; $display("FAIL rmid_no_preempt: got %b want 0010", gnt); end
        #2;
        rst_n = 1'b0;
        #1;
        nvec++; if (gnt !== 4'b0000) begin nerr++; $display("FAIL rmid_gnt_async: got %b want 0000", gnt); end
        nvec++; if (bit_rd !== 1'b0) begin nerr++; $display("FAIL rmid_bit_rd_async: got %b want 0", bit_rd); end
        nvec++; if (match_cnt !== 5'd0) begin nerr++; $display("FAIL rmid_cnt_async: got %0d want 0", match_cnt); end
        nvec++; if (done_id !== 2'd0) begin nerr++; $display("FAIL rmid_id_async: got %0d want 0", done_id); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        nvec++; if (gnt !== 4'b0001) begin nerr++; $display("FAIL rmid_first_gnt: got %b want 0001", gnt); end
        w = 0;
        while (!done && w < 40) begin @(posedge clk); #1; w++; end
        nvec++; if (done !== 1'b1) begin nerr++; $display("FAIL rmid_done: got %b want 1", done); end
        nvec++; if (done_id !== 2'd0) begin nerr++; $display("FAIL rmid_done_id: got %0d want 0", done_id); end
        nvec++; if (match_cnt !== 5'd1) begin nerr++; $display("FAIL rmid_match_cnt: got %0d want 1", match_cnt); end
        req = 4'b0000;
    endtask

    task automatic test_round_robin;
        int exp_id [5];
        int cyc;
        int lastdone;
        int w;
        logic [3:0] eg;
        logic bad;
        exp_id = '{0, 1, 2, 3, 0};
        @(negedge clk);
        rst_n = 1'b0;
        pat = 16'h0000;
        @(negedge clk);
        rst_n = 1'b1;
        req = 4'b1111;
        cyc = 0;
        lastdone = 0;
        for (int f = 0; f < 5; f++) begin
            eg = 4'b0001 << exp_id[f];
            w = 0;
            do begin @(posedge clk); #1; cyc++; w++; end while (gnt == 4'b0000 && w < 40);
            nvec++; if (gnt !== eg) begin nerr++; $display("FAIL rr%0d_gnt: got %b want %b", f, gnt, eg); end
            if (f > 0) begin
                nvec++; if (cyc - lastdone != 2) begin nerr++; $display("FAIL rr%0d_gap: got %0d want 2", f, cyc - lastdone); end
            end
            bad = 1'b0;
            w = 0;
            while (!done && w < 40) begin
                if (gnt !== eg) bad = 1'b1;
                @(posedge clk); #1; cyc++; w++;
            end
            nvec++; if (bad !== 1'b0) begin nerr++; $display("FAIL rr%0d_gnt_hold: got %b want 0", f, bad); end
            nvec++; if (done !== 1'b1) begin nerr++; $display("FAIL rr%0d_done: got %b want 1", f, done); end
            nvec++; if (done_id !== 2'(exp_id[f])) begin nerr++; $display("FAIL rr%0d_done_id: got %0d want %0d", f, done_id, exp_id[f]); end
            lastdone = cyc;
        end
        req = 4'b0000;
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        test_reset;
        test_single;
        test_patterns;
        test_abort;
        test_reset_mid;
        test_round_robin;
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/det_sched.md
DET_SCHED -- requirements
Module: det_sched

Interface
REQ-001 Parameter NREQ, default 4: number of serial requesters sharing the detector.
REQ-002 Parameter FRAME_LEN, default 16: bits per frame; legal range 4..31.
REQ-003 Parameter CNT_W, default 5: match counter width, sized so the count holds FRAME_LEN.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 req  input  NREQ  per-requester frame request, level; held until done or abort.
REQ-007 din  input  NREQ  per-requester serial data bit; only din[granted] is used.
REQ-008 gnt  output  NREQ  one-hot grant; all-zero when idle.
REQ-009 bit_rd  output  1  high in a cycle where din[granted] is consumed; requester advances its bit on this strobe.
REQ-010 done  output  1  single-cycle frame-complete pulse.
REQ-011 done_id  output  clog2(NREQ)  index of the requester whose frame completed; valid with done.
REQ-012 match_cnt  output  CNT_W  number of pattern matches in the completed frame; valid with done.

Function
REQ-013 FSM states: IDLE, GRANT, RUN, DRAIN, REPORT.
REQ-014 IDLE: if any req bit is high, select winner round-robin starting at last_id+1 (mod NREQ) -> GRANT; else stay.
REQ-015 GRANT (1 cycle): gnt[winner]=1, detector synchronously cleared, match counter cleared, bit counter cleared -> RUN.
REQ-016 RUN: exactly FRAME_LEN cycles; each cycle bit_rd=1 and din[winner] is fed to the detector; after the FRAME_LEN-th bit -> DRAIN.
REQ-017 DRAIN (1 cycle): bit_rd=0; captures any match from the final bit -> REPORT.
REQ-018 REPORT (1 cycle): done=1, done_id=winner, match_cnt=final count, gnt=0; last_id<=winner -> IDLE.
REQ-019 gnt held one-hot for winner from GRANT through DRAIN; latency req-to-gnt is 1 cycle from IDLE; frame occupancy is FRAME_LEN+3 cycles.
REQ-020 Detector pattern 1011, first bit first, overlapping: after a match, the trailing 1 counts as a matched prefix "1".
REQ-021 Detector match is a registered pulse one cycle after the consuming edge; the counter increments on each match pulse and saturates at all-ones.
REQ-022 Abort: if req[winner] falls in GRANT, RUN or DRAIN -> IDLE next cycle, no done, gnt=0, last_id<=winner.
REQ-023 New or changed req bits for other requesters during a frame are ignored until IDLE; no preemption.
REQ-024 match_cnt and done_id hold their last reported value between done pulses.

Reset
REQ-025 rst_n low: state=IDLE, gnt=0, bit_rd=0, done=0, done_id=0, match_cnt=0, last_id=NREQ-1 (so requester 0 wins first), detector in no-prefix state.
REQ-026 Reset asserted mid-frame discards the frame immediately, with no done; operation restarts from IDLE after release.

Structure
REQ-027 FSM state encoding and the detector state encoding are placed in shared package det_pkg.
REQ-028 The detector is a sub-module seq_det_1011 (clk, rst_n, clr, en, din -> match), instantiated once.

Verification
REQ-029 Single frame, req[0], bits 1011011011000000 -> gnt=0001 after 1 cycle, 16 bit_rd strobes, done with done_id=0, match_cnt=3, at cycle FRAME_LEN+3.
REQ-030 req=1111 held continuously -> grants in order 0,1,2,3,0; each gnt is one-hot; no gap beyond one IDLE cycle between frames.
REQ-031 All-zero frame -> match_cnt=0; all-ones frame -> match_cnt=0; frame 1011 ending at the last bit -> that final match is counted (DRAIN path).
REQ-032 req[2] dropped at RUN bit 5 -> gnt=0 next cycle, no done; next arbitration starts from requester 3.
REQ-033 rst_n pulsed low mid-RUN -> all outputs 0 asynchronously; first grant after release goes to requester 0.
